// File: rtl/store_queue.sv
// store_queue: in-order store queue with independent address/data writeback, in-order commit, flush of uncommitted entries.
// Latency: drain request is combinational from registered entry state (zero added cycles); alloc/commit/writeback take effect at the next edge.
// Backpressure: alloc_ready drops when full; the head entry holds mem_* stable while mem_valid & ~mem_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_*                  dispatch-side allocation (valid/ready), alloc_idx = current tail
//   wr_*                     execution writeback of address and/or data into an existing entry
//   commit_valid, flush      ROB retire of the oldest uncommitted store; mispredict discard
//   mem_*                    drain of committed, complete entries (valid/ready)
//   count, empty, full       occupancy
//   ld_*, fwd_*              store-to-load forwarding, present only when STORE_FWD_EN is defined
module store_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int ROB_W  = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef STORE_FWD_EN
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_block,
`endif
    input  logic              alloc_valid,
    input  logic [ROB_W-1:0]  alloc_rob_tag,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wr_valid,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_addr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit_valid,
    input  logic              flush,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [ROB_W-1:0]  mem_rob_tag,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    // Pointers and occupancy. r_ucnt counts uncommitted entries (cmt..tail-1);
    // it tells a full queue with every entry uncommitted apart from a full
    // queue with every entry committed, both of which have cmt == tail.
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_cmt;
    logic [IDX_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_ucnt;

    // Per-entry state
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_addr_ok;
    logic [DEPTH-1:0]  r_data_ok;
    logic [DEPTH-1:0]  r_cmtd;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ROB_W-1:0]  r_tag  [DEPTH];

    logic              w_alloc_do;
    logic              w_commit_do;
    logic              w_drain_do;
    logic              w_wr_in_rng;
    logic              w_wr_survives;
    logic              w_wr_do;
    logic [IDX_W-1:0]  w_cmt_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_ucnt_nxt;

    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] p);
        if (p == IDX_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    assign full        = (r_count == CNT_W'(DEPTH));
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign alloc_ready = ~full;
    assign alloc_idx   = r_tail;

    assign mem_valid   = r_valid[r_head] & r_cmtd[r_head] & r_addr_ok[r_head] & r_data_ok[r_head];
    assign mem_addr    = r_addr[r_head];
    assign mem_data    = r_data[r_head];
    assign mem_rob_tag = r_tag[r_head];

    // A flush drops a same-cycle allocation.
    assign w_alloc_do  = alloc_valid & alloc_ready & ~flush;
    assign w_commit_do = commit_valid & (r_ucnt != '0);
    assign w_drain_do  = mem_valid & mem_ready;
    assign w_cmt_nxt   = w_commit_do ? f_inc(r_cmt) : r_cmt;

    // Writeback lands only on a live entry. During a flush, only entries that
    // are already committed or are being committed this cycle survive.
    assign w_wr_in_rng   = (32'(wr_idx) < DEPTH);
    assign w_wr_survives = ~flush | r_cmtd[wr_idx] | (w_commit_do & (wr_idx == r_cmt));
    assign w_wr_do       = wr_valid & w_wr_in_rng & r_valid[wr_idx] & w_wr_survives
                         & ~(w_alloc_do & (wr_idx == r_tail));

    // On flush the entries removed are the uncommitted ones left after the
    // same-cycle commit: r_ucnt - commit.
    always_comb begin
        w_count_nxt = r_count;
        w_ucnt_nxt  = r_ucnt;
        if (w_drain_do) begin
            w_count_nxt = w_count_nxt - CNT_W'(1);
        end
        if (flush) begin
            w_count_nxt = w_count_nxt - (r_ucnt - CNT_W'(w_commit_do));
            w_ucnt_nxt  = '0;
        end else begin
            if (w_alloc_do) begin
                w_count_nxt = w_count_nxt + CNT_W'(1);
                w_ucnt_nxt  = w_ucnt_nxt + CNT_W'(1);
            end
            if (w_commit_do) begin
                w_ucnt_nxt = w_ucnt_nxt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_cmt     <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ucnt    <= '0;
            r_valid   <= '0;
            r_addr_ok <= '0;
            r_data_ok <= '0;
            r_cmtd    <= '0;
        end else begin
            if (w_drain_do) begin
                r_head <= f_inc(r_head);
            end
            r_cmt <= w_cmt_nxt;
            if (flush) begin
                r_tail <= w_cmt_nxt;
            end else if (w_alloc_do) begin
                r_tail <= f_inc(r_tail);
            end
            r_count <= w_count_nxt;
            r_ucnt  <= w_ucnt_nxt;

            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_do && (r_tail == IDX_W'(i))) begin
                    r_valid[i]   <= 1'b1;
                    r_addr_ok[i] <= 1'b0;
                    r_data_ok[i] <= 1'b0;
                    r_cmtd[i]    <= 1'b0;
                end
                if (w_wr_do && (wr_idx == IDX_W'(i))) begin
                    if (wr_addr_en) begin
                        r_addr_ok[i] <= 1'b1;
                    end
                    if (wr_data_en) begin
                        r_data_ok[i] <= 1'b1;
                    end
                end
                if (w_commit_do && (r_cmt == IDX_W'(i))) begin
                    r_cmtd[i] <= 1'b1;
                end
                // Flush kills every live uncommitted entry except the one
                // committing in this same cycle.
                if (flush && r_valid[i] && !r_cmtd[i]
                    && !(w_commit_do && (r_cmt == IDX_W'(i)))) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_drain_do && (r_head == IDX_W'(i))) begin
                    r_valid[i]   <= 1'b0;
                    r_cmtd[i]    <= 1'b0;
                    r_addr_ok[i] <= 1'b0;
                    r_data_ok[i] <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: it is qualified by the flags above.
    always_ff @(posedge clk) begin
        if (w_alloc_do) begin
            r_tag[r_tail] <= alloc_rob_tag;
        end
        if (w_wr_do && wr_addr_en) begin
            r_addr[wr_idx] <= wr_addr;
        end
        if (w_wr_do && wr_data_en) begin
            r_data[wr_idx] <= wr_data;
        end
    end

`ifdef STORE_FWD_EN
    // Walk live entries oldest to youngest so the last match seen is the
    // youngest one; remember whether any older entry had an unknown address
    // at the moment that match was taken.
    logic              w_match;
    logic              w_match_dok;
    logic              w_older_unknown;
    logic [DATA_W-1:0] w_match_data;

    always_comb begin
        logic             v_unknown_seen;
        int               v_pos;
        logic [IDX_W-1:0] v_idx;
        w_match         = 1'b0;
        w_match_dok     = 1'b0;
        w_older_unknown = 1'b0;
        w_match_data    = '0;
        v_unknown_seen  = 1'b0;
        v_pos           = 0;
        v_idx           = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(r_count)) begin
                v_pos = int'(r_head) + k;
                if (v_pos >= DEPTH) begin
                    v_pos = v_pos - DEPTH;
                end
                v_idx = v_pos[IDX_W-1:0];
                if (r_valid[v_idx]) begin
                    if (r_addr_ok[v_idx] && (r_addr[v_idx] == ld_addr)) begin
                        w_match         = 1'b1;
                        w_match_dok     = r_data_ok[v_idx];
                        w_match_data    = r_data[v_idx];
                        w_older_unknown = v_unknown_seen;
                    end
                    if (!r_addr_ok[v_idx]) begin
                        v_unknown_seen = 1'b1;
                    end
                end
            end
        end
    end

    assign fwd_hit   = ld_valid & w_match & w_match_dok & ~w_older_unknown;
    assign fwd_block = ld_valid & w_match & (~w_match_dok | w_older_unknown);
    assign fwd_data  = fwd_hit ? w_match_data : '0;
`endif

endmodule
